// File: rtl/msg_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : msg_pkg
//  Brief   : Shared types and constants for the message sequencer.
//  Revision: 1.0  initial release
// ============================================================================
package msg_pkg;

    localparam int DATA_W_DEF = 8;
    localparam logic [DATA_W_DEF-1:0] TERM_CHAR = 8'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/msg_store.sv
`default_nettype none
// ============================================================================
//  Module  : msg_store
//  Brief   : NUM_MSG x MAX_LEN character register file, async clear,
//            one write port and one asynchronous read port.
//  Revision: 1.0  initial release
// ============================================================================
module msg_store
    import msg_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MAX_LEN = 16,
    parameter int NUM_MSG = 2,
    parameter int MW      = 1,
    parameter int IW      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [MW-1:0]     wr_msg,
    input  logic [IW-1:0]     wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [MW-1:0]     rd_msg,
    input  logic [IW-1:0]     rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] r_mem [NUM_MSG][MAX_LEN];
    logic              w_wr_ok;
    logic              w_rd_ok;

    assign w_wr_ok = wr_en && (32'(wr_msg) < NUM_MSG) && (32'(wr_idx) < MAX_LEN);
    assign w_rd_ok = (32'(rd_msg) < NUM_MSG) && (32'(rd_idx) < MAX_LEN);
    assign rd_data = w_rd_ok ? r_mem[rd_msg][rd_idx] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int m = 0; m < NUM_MSG; m++) begin
                for (int c = 0; c < MAX_LEN; c++) begin
                    r_mem[m][c] <= '0;
                end
            end
        end else if (w_wr_ok) begin
            r_mem[wr_msg][wr_idx] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/message_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : message_sequencer
//  Brief   : Streams a stored message one char per tx_ready handshake,
//            one-shot or periodic with an idle gap between passes.
//  Revision: 1.0  initial release
// ============================================================================
module message_sequencer
    import msg_pkg::*;
#(
    parameter  int DATA_W     = DATA_W_DEF,
    parameter  int MAX_LEN    = 16,
    parameter  int NUM_MSG    = 2,
    parameter  int GAP_CYCLES = 95969,
    localparam int MW         = clog2_min1(NUM_MSG),
    localparam int IW         = clog2_min1(MAX_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              repeat_md,
    input  logic [MW-1:0]     msg_sel,
    input  logic              wr_en,
    input  logic [MW-1:0]     wr_msg,
    input  logic [IW-1:0]     wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              tx_ready,
    output logic [DATA_W-1:0] word,
    output logic              word_valid,
    output logic              tx_en,
    output logic              busy,
    output logic              msg_done
);

    localparam int            XW       = $clog2(MAX_LEN + 1);
    localparam int            GW       = clog2_min1(GAP_CYCLES);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [XW-1:0] IDX_LAST = XW'(MAX_LEN - 1);

    state_t            r_state;
    logic [MW-1:0]     r_sel;
    logic [XW-1:0]     r_idx;
    logic [GW-1:0]     r_gap;
    logic              r_hold;

    logic [MW-1:0]     w_rd_msg;
    logic [IW-1:0]     w_rd_idx;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_rd_term;
    logic              w_last;

    msg_store #(
        .DATA_W  (DATA_W),
        .MAX_LEN (MAX_LEN),
        .NUM_MSG (NUM_MSG),
        .MW      (MW),
        .IW      (IW)
    ) u_store (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en && !busy),
        .wr_msg  (wr_msg),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .rd_msg  (w_rd_msg),
        .rd_idx  (w_rd_idx),
        .rd_data (w_rd_data)
    );

    // Outside SEND the port looks at char 0 of the requested message;
    // inside SEND it pre-fetches the char after the one on the wire.
    always_comb begin
        w_rd_msg = msg_sel;
        w_rd_idx = '0;
        if (r_state == SEND) begin
            w_rd_msg = r_sel;
            w_rd_idx = IW'(r_idx + XW'(1));
        end
    end

    assign w_rd_term = (w_rd_data == DATA_W'(TERM_CHAR));
    assign w_last    = (r_idx == IDX_LAST) || w_rd_term;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_sel      <= '0;
            r_idx      <= '0;
            r_gap      <= '0;
            r_hold     <= 1'b0;
            word       <= '0;
            word_valid <= 1'b0;
            tx_en      <= 1'b0;
            busy       <= 1'b0;
            msg_done   <= 1'b0;
        end else begin
            msg_done <= 1'b0;
            if (!enable) begin
                r_hold <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (enable && !r_hold) begin
                        r_sel <= msg_sel;
                        r_idx <= '0;
                        word  <= w_rd_data;
                        if (!w_rd_term) begin
                            r_state    <= SEND;
                            word_valid <= 1'b1;
                            tx_en      <= 1'b1;
                            busy       <= 1'b1;
                        end else begin
                            msg_done <= 1'b1;
                            r_state  <= repeat_md ? GAP : IDLE;
                            busy     <= repeat_md;
                            r_hold   <= !repeat_md;
                            r_gap    <= '0;
                        end
                    end
                end
                SEND: begin
                    if (!enable) begin
                        r_state    <= IDLE;
                        word       <= '0;
                        word_valid <= 1'b0;
                        tx_en      <= 1'b0;
                        busy       <= 1'b0;
                    end else if (word_valid && tx_ready) begin
                        if (w_last) begin
                            word       <= '0;
                            word_valid <= 1'b0;
                            tx_en      <= 1'b0;
                            msg_done   <= 1'b1;
                            r_state    <= repeat_md ? GAP : IDLE;
                            busy       <= repeat_md;
                            r_hold     <= !repeat_md;
                            r_gap      <= '0;
                        end else begin
                            r_idx <= r_idx + XW'(1);
                            word  <= w_rd_data;
                        end
                    end
                end
                GAP: begin
                    // Terminal count drops to IDLE, which restarts on the next edge.
                    if (!enable) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end else if (r_gap == GAP_LAST) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_gap <= r_gap + GW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_message_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_message_sequencer
//  Brief   : Directed table-driven bench for message_sequencer.
//  Revision: 1.0  initial release
// ============================================================================
module tb_message_sequencer;

    logic       clk       = 1'b0;
    logic       rst       = 1'b0;
    logic       enable    = 1'b0;
    logic       repeat_md = 1'b0;
    logic       msg_sel   = 1'b0;
    logic       wr_en     = 1'b0;
    logic       wr_msg    = 1'b0;
    logic [3:0] wr_idx    = 4'd0;
    logic [7:0] wr_data   = 8'd0;
    logic       tx_ready  = 1'b0;
    logic [7:0] word;
    logic       word_valid;
    logic       tx_en;
    logic       busy;
    logic       msg_done;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic       en;
        logic       rdy;
        logic       sel;
        logic       rep;
        logic       wen;
        logic [7:0] wdat;
        logic [7:0] ew;
        logic       ev;
        logic       ed;
        logic       eb;
    } vec_t;

    vec_t vecs[31];

    message_sequencer #(
        .DATA_W     (8),
        .MAX_LEN    (16),
        .NUM_MSG    (2),
        .GAP_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .repeat_md  (repeat_md),
        .msg_sel    (msg_sel),
        .wr_en      (wr_en),
        .wr_msg     (wr_msg),
        .wr_idx     (wr_idx),
        .wr_data    (wr_data),
        .tx_ready   (tx_ready),
        .word       (word),
        .word_valid (word_valid),
        .tx_en      (tx_en),
        .busy       (busy),
        .msg_done   (msg_done)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic en, rdy, sel, rep, wen,
                                input logic [7:0] wdat, ew,
                                input logic ev, ed, eb);
        vec_t v;
        v.en = en; v.rdy = rdy; v.sel = sel; v.rep = rep; v.wen = wen;
        v.wdat = wdat; v.ew = ew; v.ev = ev; v.ed = ed; v.eb = eb;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_out(input string tag, input int ew, input int ev,
                             input int ed, input int eb);
        check({tag, " word"},       int'(word),       ew);
        check({tag, " word_valid"}, int'(word_valid), ev);
        check({tag, " tx_en"},      int'(tx_en),      ev);
        check({tag, " msg_done"},   int'(msg_done),   ed);
        check({tag, " busy"},       int'(busy),       eb);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_char(input logic m, input logic [3:0] i, input logic [7:0] d);
        wr_en = 1'b1; wr_msg = m; wr_idx = i; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        // Reset and "Hi\n" store, stream, stall, empty message, busy write, repeat.
        vecs[0]  = mk(1, 1, 0, 0, 0, 8'h00, 8'h48, 1, 0, 1);
        vecs[1]  = mk(1, 1, 0, 0, 0, 8'h00, 8'h69, 1, 0, 1);
        vecs[2]  = mk(1, 1, 0, 0, 0, 8'h00, 8'h0A, 1, 0, 1);
        vecs[3]  = mk(1, 1, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0);
        vecs[4]  = mk(1, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        vecs[6]  = mk(1, 1, 0, 0, 0, 8'h00, 8'h48, 1, 0, 1);
        vecs[7]  = mk(1, 1, 0, 0, 0, 8'h00, 8'h69, 1, 0, 1);
        for (int k = 8; k <= 12; k++) vecs[k] = mk(1, 0, 0, 0, 0, 8'h00, 8'h69, 1, 0, 1);
        vecs[13] = mk(1, 1, 0, 0, 0, 8'h00, 8'h0A, 1, 0, 1);
        vecs[14] = mk(1, 1, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0);
        vecs[15] = mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        vecs[16] = mk(1, 0, 1, 1, 0, 8'h00, 8'h00, 0, 1, 1);
        vecs[17] = mk(1, 0, 1, 1, 1, 8'h5A, 8'h00, 0, 0, 1);
        vecs[18] = mk(0, 0, 1, 1, 0, 8'h00, 8'h00, 0, 0, 0);
        vecs[19] = mk(1, 0, 1, 0, 0, 8'h00, 8'h00, 0, 1, 0);
        vecs[20] = mk(0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        vecs[21] = mk(0, 0, 1, 0, 1, 8'h41, 8'h00, 0, 0, 0);
        vecs[22] = mk(1, 1, 1, 1, 0, 8'h00, 8'h41, 1, 0, 1);
        vecs[23] = mk(1, 1, 1, 1, 0, 8'h00, 8'h00, 0, 1, 1);
        vecs[24] = mk(1, 1, 1, 1, 0, 8'h00, 8'h00, 0, 0, 1);
        vecs[25] = mk(1, 1, 1, 1, 0, 8'h00, 8'h00, 0, 0, 1);
        vecs[26] = mk(1, 1, 1, 1, 0, 8'h00, 8'h00, 0, 0, 1);
        vecs[27] = mk(1, 1, 1, 1, 0, 8'h00, 8'h00, 0, 0, 0);
        vecs[28] = mk(1, 1, 1, 1, 0, 8'h00, 8'h41, 1, 0, 1);
        vecs[29] = mk(1, 1, 1, 1, 0, 8'h00, 8'h00, 0, 1, 1);
        vecs[30] = mk(0, 1, 1, 1, 0, 8'h00, 8'h00, 0, 0, 0);

        tick();
        tick();
        check_out("reset", 0, 0, 0, 0);
        rst = 1'b1;
        tick();

        write_char(1'b0, 4'd0, 8'h48);
        write_char(1'b0, 4'd1, 8'h69);
        write_char(1'b0, 4'd2, 8'h0A);

        for (int k = 0; k < 31; k++) begin
            enable    = vecs[k].en;
            tx_ready  = vecs[k].rdy;
            msg_sel   = vecs[k].sel;
            repeat_md = vecs[k].rep;
            wr_en     = vecs[k].wen;
            wr_msg    = 1'b1;
            wr_idx    = 4'd0;
            wr_data   = vecs[k].wdat;
            tick();
            wr_en = 1'b0;
            check_out($sformatf("vec[%0d]", k), int'(vecs[k].ew), int'(vecs[k].ev),
                      int'(vecs[k].ed), int'(vecs[k].eb));
        end

        // Full-length message without a terminator.
        enable = 1'b0; tx_ready = 1'b0; msg_sel = 1'b0; repeat_md = 1'b0;
        for (int i = 0; i < 16; i++) write_char(1'b0, 4'(i), 8'(8'h61 + i));
        enable = 1'b1; tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check($sformatf("full[%0d] word", i), int'(word), 8'h61 + i);
            check($sformatf("full[%0d] word_valid", i), int'(word_valid), 1);
        end
        tick();
        check_out("full end", 0, 0, 1, 0);
        tick();
        check_out("full hold", 0, 0, 0, 0);

        // Abort by enable, with an accept on the same edge.
        enable = 1'b0; tx_ready = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        check_out("abort start", 8'h61, 1, 0, 1);
        enable = 1'b0; tx_ready = 1'b1;
        tick();
        check_out("abort", 0, 0, 0, 0);

        // Asynchronous reset mid-SEND clears outputs and the store.
        enable = 1'b1; tx_ready = 1'b0;
        tick();
        check_out("rst start", 8'h61, 1, 0, 1);
        #2 rst = 1'b0;
        #1 check_out("rst async", 0, 0, 0, 0);
        enable = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        enable = 1'b1;
        tick();
        check_out("post-rst empty", 0, 0, 1, 0);
        enable = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
